// File: rtl/flp_pkg.sv
// Shared types and helpers for the floating-point max-reduction engine.
// The controller and the comparator both call flp_max_sel so that the index
// update and the selected value always agree bit for bit.
package flp_pkg;

    localparam int FLP_COUNTW_DEF = 8;
    localparam int FLP_MAXW       = 64;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ACC  = ST_ACC,
        DONE = ST_DONE
    } state_t;

    // Returns 1 when b is the maximum. Operands are zero-extended to FLP_MAXW;
    // 'bits' is the real operand width with the sign at bits-1.
    // Ties keep a when positive and take b when negative; +0 beats -0 because
    // a sign difference is decided before magnitudes are looked at.
    function automatic logic flp_max_sel(input logic [FLP_MAXW-1:0] a,
                                         input logic [FLP_MAXW-1:0] b,
                                         input int unsigned          bits);
        logic [FLP_MAXW-1:0] one;
        logic [FLP_MAXW-1:0] sign_m;
        logic [FLP_MAXW-1:0] mag_m;
        logic                sa;
        logic                sb;
        logic [FLP_MAXW-1:0] ma;
        logic [FLP_MAXW-1:0] mb;
        logic                sel;
        one    = {{(FLP_MAXW-1){1'b0}}, 1'b1};
        sign_m = one << (bits - 1);
        mag_m  = sign_m - one;
        sa     = |(a & sign_m);
        sb     = |(b & sign_m);
        ma     = a & mag_m;
        mb     = b & mag_m;
        if (sa != sb) begin
            sel = ~sb;
        end else if (!sa) begin
            sel = (mb > ma);
        end else begin
            sel = (mb <= ma);
        end
        return sel;
    endfunction

endpackage

// File: rtl/flpcomp.sv
// Combinational max comparator: z is whichever of a/b flp_max_sel picks.
module flpcomp
    import flp_pkg::*;
#(
    parameter int Bits = 32
) (
    input  logic [Bits-1:0] a_i,
    input  logic [Bits-1:0] b_i,
    output logic [Bits-1:0] z_o
);

    logic sel_b;

    // Select the larger operand under the sign/magnitude ordering.
    always_comb begin
        sel_b = flp_max_sel(FLP_MAXW'(a_i), FLP_MAXW'(b_i), Bits);
        z_o   = sel_b ? b_i : a_i;
    end

endmodule

// File: rtl/flp_max_reduce.sv
// Streaming max-reduction: folds one operand per cycle into a running maximum
// and returns value, index of the winning element and element count.
//
// state | meaning
// IDLE  | no element held, ready for the first element of a vector
// ACC   | accumulating, running max held in acc_q
// DONE  | result held on m_*, waiting for m_ready
module flp_max_reduce
    import flp_pkg::*;
#(
    parameter int Bits   = 32,
    parameter int CountW = FLP_COUNTW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [Bits-1:0]   s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [Bits-1:0]   m_data,
    output logic [CountW-1:0] m_index,
    output logic [CountW-1:0] m_count,
    output logic              m_ovf
);

    localparam logic [CountW-1:0] CNT_MAX = {CountW{1'b1}};
    localparam logic [CountW-1:0] CNT_ONE = {{(CountW-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [Bits-1:0]   acc_q, acc_d;
    logic [CountW-1:0] idx_q, idx_d;
    logic [CountW-1:0] cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [Bits-1:0]   cmp_z;
    logic              sel_b;

    flpcomp #(.Bits(Bits)) u_flpcomp (
        .a_i (acc_q),
        .b_i (s_data),
        .z_o (cmp_z)
    );

    // Handshake flags depend on state only, so m_ready never reaches s_ready.
    always_comb begin
        s_ready = (state_q != DONE);
        m_valid = (state_q == DONE);
        sel_b   = flp_max_sel(FLP_MAXW'(acc_q), FLP_MAXW'(s_data), Bits);
    end

    // Next-state and datapath update; clr overrides every other condition.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clr) begin
            state_d = IDLE;
            acc_d   = '0;
            idx_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_valid) begin
                        acc_d   = s_data;
                        idx_d   = '0;
                        cnt_d   = CNT_ONE;
                        ovf_d   = 1'b0;
                        state_d = s_last ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (s_valid) begin
                        acc_d = cmp_z;
                        if (sel_b) begin
                            idx_d = cnt_q;
                        end
                        // Once saturated the count stays pinned and the vector
                        // is flagged; comparisons still run.
                        if (cnt_q == CNT_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                        if (s_last) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (m_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and result registers; reset aborts any vector in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign m_data  = acc_q;
    assign m_index = idx_q;
    assign m_count = cnt_q;
    assign m_ovf   = ovf_q;

endmodule

// File: tb/tb_flp_max_reduce.sv
// Directed bench for flp_max_reduce: one 16-bit instance with an 8-bit count
// and one with a 2-bit count for saturation, both fed the same stream.
module tb_flp_max_reduce;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_last;
    logic        m_ready;

    logic        sr8, v8, o8;
    logic [15:0] d8;
    logic [7:0]  i8, c8;
    logic        sr2, v2, o2;
    logic [15:0] d2;
    logic [1:0]  i2, c2;

    int n_cmp;
    int n_bad;

    flp_max_reduce #(.Bits(16), .CountW(8)) u_dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .s_valid (s_valid),
        .s_ready (sr8),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (v8),
        .m_ready (m_ready),
        .m_data  (d8),
        .m_index (i8),
        .m_count (c8),
        .m_ovf   (o8)
    );

    flp_max_reduce #(.Bits(16), .CountW(2)) u_dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .s_valid (s_valid),
        .s_ready (sr2),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (v2),
        .m_ready (m_ready),
        .m_data  (d2),
        .m_index (i2),
        .m_count (c2),
        .m_ovf   (o2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one element for one clock; returns 1 time unit after the edge.
    task automatic drive(input logic [15:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic consume();
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({sr8, v8, d8, i8, c8, o8} !== {1'b1, 1'b0, 16'h0, 8'd0, 8'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset8: got rdy=%b v=%b d=%h i=%0d c=%0d o=%b want rdy=1 v=0 d=0000 i=0 c=0 o=0",
                     sr8, v8, d8, i8, c8, o8);
        end
        n_cmp++;
        if ({sr2, v2, d2, i2, c2, o2} !== {1'b1, 1'b0, 16'h0, 2'd0, 2'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset2: got rdy=%b v=%b d=%h i=%0d c=%0d o=%b want all reset values",
                     sr2, v2, d2, i2, c2, o2);
        end
    endtask

    task automatic test_single();
        drive(16'h3C00, 1'b1);
        n_cmp++;
        if ({v8, d8, i8, c8, o8} !== {1'b1, 16'h3C00, 8'd0, 8'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL single: got v=%b d=%h i=%0d c=%0d o=%b want v=1 d=3c00 i=0 c=1 o=0",
                     v8, d8, i8, c8, o8);
        end
        consume();
    endtask

    task automatic test_mixed();
        drive(16'hC200, 1'b0);
        drive(16'h3C00, 1'b0);
        drive(16'h4000, 1'b0);
        drive(16'hBC00, 1'b1);
        n_cmp++;
        if ({v8, d8, i8, c8, o8} !== {1'b1, 16'h4000, 8'd2, 8'd4, 1'b0}) begin
            n_bad++;
            $display("FAIL mixed: got v=%b d=%h i=%0d c=%0d o=%b want v=1 d=4000 i=2 c=4 o=0",
                     v8, d8, i8, c8, o8);
        end
        consume();
    endtask

    task automatic test_ties();
        drive(16'h3C00, 1'b0);
        drive(16'h3C00, 1'b1);
        n_cmp++;
        if ({d8, i8, c8} !== {16'h3C00, 8'd0, 8'd2}) begin
            n_bad++;
            $display("FAIL tie_pos: got d=%h i=%0d c=%0d want d=3c00 i=0 c=2", d8, i8, c8);
        end
        consume();
        drive(16'hBC00, 1'b0);
        drive(16'hBC00, 1'b1);
        n_cmp++;
        if ({d8, i8, c8} !== {16'hBC00, 8'd1, 8'd2}) begin
            n_bad++;
            $display("FAIL tie_neg: got d=%h i=%0d c=%0d want d=bc00 i=1 c=2", d8, i8, c8);
        end
        consume();
        drive(16'h8000, 1'b0);
        drive(16'h0000, 1'b1);
        n_cmp++;
        if ({d8, i8} !== {16'h0000, 8'd1}) begin
            n_bad++;
            $display("FAIL tie_zero: got d=%h i=%0d want d=0000 i=1", d8, i8);
        end
        consume();
        // A smaller positive after a larger one must leave the first in place.
        drive(16'h4400, 1'b0);
        drive(16'h3C00, 1'b0);
        drive(16'hC400, 1'b1);
        n_cmp++;
        if ({d8, i8, c8} !== {16'h4400, 8'd0, 8'd3}) begin
            n_bad++;
            $display("FAIL keep_first: got d=%h i=%0d c=%0d want d=4400 i=0 c=3", d8, i8, c8);
        end
        consume();
        // Among negatives the smaller magnitude wins.
        drive(16'hC400, 1'b0);
        drive(16'hBC00, 1'b0);
        drive(16'hC000, 1'b1);
        n_cmp++;
        if ({d8, i8, c8} !== {16'hBC00, 8'd1, 8'd3}) begin
            n_bad++;
            $display("FAIL neg_order: got d=%h i=%0d c=%0d want d=bc00 i=1 c=3", d8, i8, c8);
        end
        consume();
    endtask

    task automatic test_backpressure();
        drive(16'h4000, 1'b1);
        s_valid = 1'b1;
        s_data  = 16'h7BFF;
        s_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if ({v8, sr8, d8, i8, c8} !== {1'b1, 1'b0, 16'h4000, 8'd0, 8'd1}) begin
                n_bad++;
                $display("FAIL hold_%0d: got v=%b rdy=%b d=%h i=%0d c=%0d want v=1 rdy=0 d=4000 i=0 c=1",
                         k, v8, sr8, d8, i8, c8);
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        #1;
        n_cmp++;
        if (sr8 !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_comb: got s_ready=%b want 0 while m_ready rises in DONE", sr8);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        n_cmp++;
        if ({v8, sr8} !== {1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL release: got v=%b rdy=%b want v=0 rdy=1", v8, sr8);
        end
    endtask

    task automatic test_back_to_back();
        drive(16'h3800, 1'b0);
        drive(16'h3C00, 1'b1);
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'h4200;
        s_last  = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        n_cmp++;
        if ({v8, sr8} !== {1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL b2b_bubble: got v=%b rdy=%b want v=0 rdy=1", v8, sr8);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        n_cmp++;
        if ({v8, d8, i8, c8} !== {1'b1, 16'h4200, 8'd0, 8'd1}) begin
            n_bad++;
            $display("FAIL b2b_next: got v=%b d=%h i=%0d c=%0d want v=1 d=4200 i=0 c=1",
                     v8, d8, i8, c8);
        end
        consume();
    endtask

    task automatic test_abort();
        drive(16'h3C00, 1'b0);
        drive(16'h4800, 1'b0);
        clr = 1'b1;
        drive(16'h7000, 1'b1);
        clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({v8, sr8} !== {1'b0, 1'b1}) begin
                n_bad++;
                $display("FAIL clr_%0d: got v=%b rdy=%b want v=0 rdy=1", k, v8, sr8);
            end
            @(posedge clk);
            #1;
        end
        drive(16'h4000, 1'b1);
        n_cmp++;
        if ({v8, d8, i8, c8} !== {1'b1, 16'h4000, 8'd0, 8'd1}) begin
            n_bad++;
            $display("FAIL after_clr: got v=%b d=%h i=%0d c=%0d want v=1 d=4000 i=0 c=1",
                     v8, d8, i8, c8);
        end
        // clr beats m_ready and drops a held result.
        m_ready = 1'b1;
        clr     = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        clr     = 1'b0;
        n_cmp++;
        if ({v8, sr8, c8} !== {1'b0, 1'b1, 8'd0}) begin
            n_bad++;
            $display("FAIL clr_done: got v=%b rdy=%b c=%0d want v=0 rdy=1 c=0", v8, sr8, c8);
        end
    endtask

    task automatic test_async_reset();
        drive(16'h3C00, 1'b0);
        drive(16'h4000, 1'b0);
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({sr8, v8, d8, i8, c8, o8} !== {1'b1, 1'b0, 16'h0, 8'd0, 8'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL async_rst: got rdy=%b v=%b d=%h i=%0d c=%0d o=%b want reset values",
                     sr8, v8, d8, i8, c8, o8);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(16'h3400, 1'b1);
        n_cmp++;
        if ({v8, d8, c8} !== {1'b1, 16'h3400, 8'd1}) begin
            n_bad++;
            $display("FAIL post_rst: got v=%b d=%h c=%0d want v=1 d=3400 c=1", v8, d8, c8);
        end
        consume();
    endtask

    task automatic test_overflow();
        drive(16'h3000, 1'b0);
        drive(16'h3400, 1'b0);
        drive(16'h3800, 1'b0);
        drive(16'h4400, 1'b0);
        drive(16'h3C00, 1'b1);
        n_cmp++;
        if ({v2, d2, i2, c2, o2} !== {1'b1, 16'h4400, 2'd3, 2'd3, 1'b1}) begin
            n_bad++;
            $display("FAIL ovf_sat: got v=%b d=%h i=%0d c=%0d o=%b want v=1 d=4400 i=3 c=3 o=1",
                     v2, d2, i2, c2, o2);
        end
        n_cmp++;
        if ({d8, i8, c8, o8} !== {16'h4400, 8'd3, 8'd5, 1'b0}) begin
            n_bad++;
            $display("FAIL ovf_wide: got d=%h i=%0d c=%0d o=%b want d=4400 i=3 c=5 o=0",
                     d8, i8, c8, o8);
        end
        consume();
        // Selection after saturation still lands on the pinned index.
        drive(16'h3000, 1'b0);
        drive(16'h3400, 1'b0);
        drive(16'h3800, 1'b0);
        drive(16'h3900, 1'b0);
        drive(16'h4800, 1'b1);
        n_cmp++;
        if ({d2, i2, c2, o2} !== {16'h4800, 2'd3, 2'd3, 1'b1}) begin
            n_bad++;
            $display("FAIL ovf_late: got d=%h i=%0d c=%0d o=%b want d=4800 i=3 c=3 o=1",
                     d2, i2, c2, o2);
        end
        consume();
        drive(16'h3C00, 1'b1);
        n_cmp++;
        if ({i2, c2, o2} !== {2'd0, 2'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL ovf_clear: got i=%0d c=%0d o=%b want i=0 c=1 o=0", i2, c2, o2);
        end
        consume();
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        clr     = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_mixed();
        test_ties();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/flp_max_reduce.md
# flp_max_reduce

Streaming max-reduction engine for floating-point vectors. Accepts one operand per cycle over a valid/ready stream, folds it into a running maximum through a single instance of the team's combinational max comparator `flpcomp`, and emits one result per vector:

- the maximum value,
- its element index,
- the element count.

It is the sequencing layer between upstream vector producers and the comparator datapath.

## Interface
Parameters:
- `Bits`, 32, operand width (sign at `Bits-1`).
- `CountW`, 8, width of count/index fields.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous abort of the current vector.
- `s_valid` in 1: input operand valid.
- `s_ready` out 1: engine can accept an operand.
- `s_data` in `Bits`: operand.
- `s_last` in 1: operand is the final element of the vector.
- `m_valid` out 1: result valid.
- `m_ready` in 1: result consumed.
- `m_data` out `Bits`: maximum value.
- `m_index` out `CountW`: zero-based index of the selected element.
- `m_count` out `CountW`: number of elements accepted.
- `m_ovf` out 1: element count exceeded `2^CountW-1`.

## Operation
- Transfer on the input side: `s_valid && s_ready`. Transfer on the output side: `m_valid && m_ready`.
- States:
  - IDLE: no element held.
  - ACC: accumulating.
  - DONE: result held.
- IDLE:
  - `s_ready=1`.
  - A transfer loads `acc=s_data`, `idx=0`, `cnt=1`.
  - Next state is DONE if `s_last`, else ACC.
- ACC:
  - `s_ready=1`.
  - A transfer presents `a=acc`, `b=s_data` to the comparator.
  - `acc<=z`.
  - If the comparator selects b, then `idx<=cnt`.
  - `cnt<=cnt+1`.
  - Next state is DONE if `s_last`.
- DONE:
  - `s_ready=0` and `m_valid=1`.
  - `m_data`, `m_index` and `m_count` are stable.
  - An output transfer moves to IDLE.
- Comparator semantics (selection drives `idx`):
  - Magnitude compare is on bits `[Bits-2:0]`.
  - Signs differ: the positive operand wins.
  - Both positive: the larger magnitude wins; equal magnitude selects a (earliest element kept).
  - Both negative: the smaller magnitude wins; equal magnitude selects b (latest element).
  - `+0` vs `-0`: the positive zero wins.
  - NaN/Inf are not special-cased; they are ordered by bit pattern as above.
- Saturation:
  - `cnt` saturates at all-ones, and `m_ovf` is set for that vector.
  - `idx` written after saturation takes the saturated value.
  - Comparisons continue after saturation.
- `clr`:
  - From any state, `clr` returns to IDLE, drops the partial or held result, and deasserts `m_valid`.
  - An input transfer in the same cycle as `clr` is discarded.
  - `clr` has priority over `s_last` and `m_ready`.

## Timing
- Reset values:
  - `s_ready=1`, `m_valid=0`.
  - `m_data=0`, `m_index=0`, `m_count=0`, `m_ovf=0`.
  - State is IDLE.
- `s_ready` is a function of state only; there is no combinational path from `m_ready` to `s_ready`.
- Latency: `m_valid` rises on the clock edge that accepts the `s_last` element, so the result is visible the cycle after the last transfer.
- Throughput:
  - One element per cycle within a vector.
  - One bubble cycle per vector minimum: the DONE cycle plus the IDLE acceptance.
  - A vector of N elements occupies at least N+1 cycles.
- `m_*` outputs are registered and are held unchanged while `m_valid && !m_ready`.
- Asynchronous reset mid-vector aborts immediately; no result is produced.

## Structure
- Package `flp_pkg` holds:
  - the `state_t` enum (IDLE, ACC, DONE),
  - the default `CountW`,
  - a `flp_max_sel(a,b)` function returning the select-b flag, so that the controller's index update and the comparator agree bit-exactly.
- One sub-module instance: `flpcomp #(.Bits(Bits))` on the `acc`/`s_data` path.
- The select-b flag is computed in the controller via `flp_max_sel`; the comparator output is not used to infer selection by equality.

## Test plan
- Single element, `Bits=16`: `s_data=0x3C00`, `s_last=1` -> next cycle `m_data=0x3C00`, `m_index=0`, `m_count=1`, `m_ovf=0`.
- Mixed signs: sequence `0xC200, 0x3C00, 0x4000, 0xBC00` (last on 4th) -> `m_data=0x4000`, `m_index=2`, `m_count=4`.
- Ties:
  - `0x3C00, 0x3C00` -> `m_index=0`.
  - `0xBC00, 0xBC00` -> `m_index=1`.
  - `0x8000, 0x0000` -> `m_data=0x0000`, `m_index=1`.
- Backpressure:
  - Hold `m_ready=0` for 5 cycles after a result -> outputs stable and `s_ready=0` throughout.
  - Release -> IDLE and `s_ready=1` next cycle.
- Abort:
  - `clr` asserted with `s_valid`/`s_last` on the 3rd element -> no `m_valid`; the next vector `0x4000` alone returns `m_count=1`.
  - `rst_n` pulsed mid-vector -> all outputs return to reset values.
- Overflow, `CountW=2`: 5 elements with the maximum at element 4 -> `m_count=3`, `m_index=3`, `m_ovf=1`.
